// File: rtl/wired_bus_resolver.sv
// Resolves N enabled W-bit drivers onto one registered bus (wired-OR or wired-AND),
// with contention detection, saturating conflict statistics and a stability qualifier.
module wired_bus_resolver #(
  parameter int N          = 4,
  parameter int W          = 1,
  parameter int MODE       = 0,
  parameter int STABLE_CYC = 3,
  parameter int CNT_W      = 8,
  localparam int AW        = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     drv_en,
  input  logic [N*W-1:0]   drv_data,
  input  logic             clr_stats,
  output logic [W-1:0]     bus_q,
  output logic [AW-1:0]    active_cnt,
  output logic             floating,
  output logic             conflict,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_count,
  output logic             bus_stable
);

  localparam int SW = 8;
  localparam logic [W-1:0]  IDLE     = (MODE == 0) ? {W{1'b0}} : {W{1'b1}};
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SW-1:0] sat_inc_stab(input logic [SW-1:0] v);
    return (v >= STAB_MAX) ? STAB_MAX : v + SW'(1);
  endfunction

  logic [W-1:0]  w_or;
  logic [W-1:0]  w_and;
  logic [W-1:0]  w_bus;
  logic [AW-1:0] w_cnt;
  logic          w_conflict;

  // Disabled slices are never read, so X on them cannot leak into the bus.
  always_comb begin
    w_or  = '0;
    w_and = '1;
    w_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (drv_en[i]) begin
        w_or  = w_or | drv_data[i*W +: W];
        w_and = w_and & drv_data[i*W +: W];
        w_cnt = w_cnt + AW'(1);
      end
    end
    w_bus      = (MODE == 0) ? w_or : w_and;
    // Enabled slices all agree exactly when their OR equals their AND.
    w_conflict = (w_cnt >= AW'(2)) && (w_or != w_and);
  end

  logic [W-1:0]     r_bus;
  logic [AW-1:0]    r_active;
  logic             r_floating;
  logic             r_conflict;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;
  logic [SW-1:0]    r_stab;

  // Register stage: resolved bus, status and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus      <= IDLE;
      r_active   <= '0;
      r_floating <= 1'b1;
      r_conflict <= 1'b0;
      r_sticky   <= 1'b0;
      r_count    <= '0;
      r_stab     <= '0;
    end else begin
      r_bus      <= w_bus;
      r_active   <= w_cnt;
      r_floating <= (w_cnt == '0);
      r_conflict <= w_conflict;
      if (w_bus != r_bus) r_stab <= '0;
      else                r_stab <= sat_inc_stab(r_stab);
      // A clear on the same edge as a new conflict takes precedence.
      if (clr_stats) begin
        r_sticky <= 1'b0;
        r_count  <= '0;
      end else if (w_conflict) begin
        r_sticky <= 1'b1;
        r_count  <= sat_inc_cnt(r_count);
      end
    end
  end

  assign bus_q           = r_bus;
  assign active_cnt      = r_active;
  assign floating        = r_floating;
  assign conflict        = r_conflict;
  assign conflict_sticky = r_sticky;
  assign conflict_count  = r_count;
  assign bus_stable      = (r_stab == STAB_MAX);

endmodule
